// File: rtl/mem_access_unit_pkg.sv
// Shared widths and access-size encodings for the memory access unit.
//   FULLW    : CPU/RAM data and address width
//   BYTEW    : width of one byte lane
//   MAU_BYTE : req_byte value selecting a byte access
//   MAU_WORD : req_byte value selecting a word access
package mem_access_unit_pkg;

  localparam int unsigned FULLW = 32;
  localparam int unsigned BYTEW = 8;

  localparam logic MAU_BYTE = 1'b1;
  localparam logic MAU_WORD = 1'b0;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle between CPU, memory access unit and block RAM.
//   req_*  : CPU request handshake and payload
//   resp_* : response handshake and payload back to the CPU
//   ram_*  : RAM d/ad/we/en port and its q return
// Modports: slave = the access unit, master = the CPU/RAM environment.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic             req_byte;
  logic             req_signed;
  logic [FULLW-1:0] req_addr;
  logic [FULLW-1:0] req_wdata;

  logic             resp_valid;
  logic             resp_ready;
  logic [FULLW-1:0] resp_rdata;
  logic             resp_err;

  logic             ram_en;
  logic             ram_we;
  logic [FULLW-1:0] ram_ad;
  logic [FULLW-1:0] ram_d;
  logic [FULLW-1:0] ram_q;

  modport slave (
    input  req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output ram_en, ram_we, ram_ad, ram_d,
    input  ram_q
  );

  modport master (
    output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  ram_en, ram_we, ram_ad, ram_d,
    output ram_q
  );

endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// Byte-lane helper for a big-endian RAM: the addressed byte sits in the MSB lane.
//   word_i   : word read from RAM
//   byte_i   : byte to be stored
//   signed_i : sign-extend (1) or zero-extend (0) the extracted byte
//   ext_o    : extracted MSB-lane byte, extended to a full word
//   merged_o : word_i with its MSB lane replaced by byte_i
module mem_byte_lane
  import mem_access_unit_pkg::*;
(
  input  logic [FULLW-1:0] word_i,
  input  logic [BYTEW-1:0] byte_i,
  input  logic             signed_i,
  output logic [FULLW-1:0] ext_o,
  output logic [FULLW-1:0] merged_o
);

  logic [BYTEW-1:0] lane;
  logic             fill;

  assign lane     = word_i[FULLW-1 -: BYTEW];
  assign fill     = signed_i & lane[BYTEW-1];
  assign ext_o    = {{(FULLW-BYTEW){fill}}, lane};
  assign merged_o = {byte_i, word_i[FULLW-BYTEW-1:0]};

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide, byte-addressed block RAM.
// Accepts one request at a time, performs read-modify-write for byte stores
// and returns load data / completion through a response handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request, response and RAM port bundle (slave modport)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);

  // Highest legal address: every access touches four bytes.
  localparam logic [FULLW-1:0] MAX_ADDR = FULLW'((64'd1 << ADDR_WIDTH) - 64'd4);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_MERGE   = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic             byte_q, byte_d;
  logic             signed_q, signed_d;
  logic [FULLW-1:0] addr_q, addr_d;
  logic [FULLW-1:0] wdata_q, wdata_d;
  logic [FULLW-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [FULLW-1:0] lane_ext;
  logic [FULLW-1:0] lane_merged;

  mem_byte_lane u_lane (
    .word_i   (bus.ram_q),
    .byte_i   (wdata_q[BYTEW-1:0]),
    .signed_i (signed_q),
    .ext_o    (lane_ext),
    .merged_o (lane_merged)
  );

  // State and request/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      byte_q   <= MAU_WORD;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state and state-decoded handshake/RAM outputs.
  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    byte_d         = byte_q;
    signed_d       = signed_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.ram_en     = 1'b0;
    bus.ram_we     = 1'b0;
    bus.ram_ad     = '0;
    bus.ram_d      = '0;

    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          byte_d   = bus.req_byte;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          if (bus.req_addr > MAX_ADDR) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        bus.ram_en = 1'b1;
        bus.ram_ad = addr_q;
        if (we_q && (byte_q == MAU_WORD)) begin
          bus.ram_we = 1'b1;
          bus.ram_d  = wdata_q;
          state_d    = ST_RESP;
        end else if (we_q) begin
          state_d = ST_MERGE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      // RAM data from the ACCESS read is valid this cycle.
      ST_CAPTURE: begin
        rdata_d = (byte_q == MAU_BYTE) ? lane_ext : bus.ram_q;
        state_d = ST_RESP;
      end

      ST_MERGE: begin
        bus.ram_en = 1'b1;
        bus.ram_we = 1'b1;
        bus.ram_ad = addr_q;
        bus.ram_d  = lane_merged;
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule
